// File: rtl/uart_tx_mmio_if.sv
// Data-bus port bundle between the core and the memory-mapped UART transmitter.
// The core drives address/strobe/store data; the UART answers with hit and read data.
interface uart_tx_mmio_if;
    logic        d_wr_en;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic        hit;
    logic [31:0] dRdata;

    modport master (
        output d_wr_en,
        output dAddr,
        output dWdata,
        input  hit,
        input  dRdata
    );

    modport slave (
        input  d_wr_en,
        input  dAddr,
        input  dWdata,
        output hit,
        output dRdata
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a small TX FIFO and a
// baud-rate state machine serialises the queued bytes on tx, LSB first.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          BAUD_DIV   = 868,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_mmio_if.slave  bus,
    output logic           tx
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST_C = BW'(BAUD_DIV - 1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enable_q, enable_d;
    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic          hit_s;
    logic [1:0]    off_s;
    logic          full_s;
    logic          empty_s;
    logic          busy_s;
    logic          push_s;
    logic          pop_s;
    logic          baud_end_s;
    logic [31:0]   status_s;
    logic [31:0]   rdata_s;
    logic          unused_bits_s;

    assign unused_bits_s = ^{bus.dWdata[31:8], bus.dAddr[1:0]};

    // Address decode and FIFO level flags
    always_comb begin
        hit_s   = (bus.dAddr[31:4] == BASE_ADDR[31:4]);
        off_s   = bus.dAddr[3:2];
        full_s  = (count_q == DEPTH_C);
        empty_s = (count_q == {CW{1'b0}});
        busy_s  = (state_q != ST_IDLE);
        push_s  = bus.d_wr_en & hit_s & (off_s == OFF_TXDATA) & ~full_s;
    end

    // Serialiser: start bit, eight data bits LSB first, stop bit, each BAUD_DIV cycles
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop_s      = 1'b0;
        baud_end_s = (baud_q == BAUD_LAST_C);
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = {BW{1'b0}};
                if (enable_q && !empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_d    = {BW{1'b0}};
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d = {BW{1'b0}};
                    // Chain straight into the next start bit so frames leave no idle gap
                    if (enable_q && !empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = {BW{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage, pointers, explicit count and the enable bit
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = bus.dWdata[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (bus.d_wr_en && hit_s && (off_s == OFF_CTRL)) begin
            enable_d = bus.dWdata[0];
        end else begin
            enable_d = enable_q;
        end
    end

    // Zero-latency register read mux
    always_comb begin
        status_s            = 32'd0;
        status_s[0]         = busy_s;
        status_s[1]         = full_s;
        status_s[2]         = empty_s;
        status_s[8 +: CW]   = count_q;
        rdata_s             = 32'd0;
        if (hit_s) begin
            case (off_s)
                OFF_STATUS: rdata_s = status_s;
                OFF_CTRL:   rdata_s = {31'd0, enable_q};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.hit    = hit_s;
    assign bus.dRdata = rdata_s;
    assign tx         = tx_q;

    // State register; reset drops any partial frame and forces the line idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            enable_q  <= 1'b1;
            state_q   <= ST_IDLE;
            baud_q    <= {BW{1'b0}};
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            enable_q  <= enable_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: a queue-based line model predicts tx,
// hit and read data every cycle, plus directed frame decoding of key scenarios.
module tb_uart_tx_mmio;

    localparam int          BAUD  = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int vec_count   = 0;
    int miscompares = 0;

    // Reference model: queued bytes, remaining line levels (one per cycle), enable bit
    logic [7:0] m_fifo [$];
    bit         m_line [$];
    bit         m_en = 1'b1;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_count++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        logic [31:0] r;
        int          n;
        r = 32'd0;
        n = m_fifo.size();
        if (addr[31:4] == BASE[31:4]) begin
            if (addr[3:2] == 2'd1) begin
                r[0]    = (m_line.size() > 0);
                r[1]    = (n == DEPTH);
                r[2]    = (n == 0);
                r[12:8] = 5'(n);
            end else if (addr[3:2] == 2'd2) begin
                r[0] = m_en;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        int         n_old;
        bit         en_old;
        bit         sel;
        bit         lvl;
        logic [1:0] off;
        logic [7:0] b;
        if (rst) begin
            m_fifo.delete();
            m_line.delete();
            m_en = 1'b1;
            return;
        end
        n_old  = m_fifo.size();
        en_old = m_en;
        sel    = (bus.dAddr[31:4] == BASE[31:4]);
        off    = bus.dAddr[3:2];
        if (m_line.size() > 0) void'(m_line.pop_front());
        if (m_line.size() == 0 && en_old && n_old > 0) begin
            b = m_fifo.pop_front();
            for (int k = 0; k < 10; k++) begin
                if (k == 0)      lvl = 1'b0;
                else if (k == 9) lvl = 1'b1;
                else             lvl = b[k-1];
                repeat (BAUD) m_line.push_back(lvl);
            end
        end
        if (bus.d_wr_en && sel && off == 2'd0 && n_old < DEPTH) m_fifo.push_back(bus.dWdata[7:0]);
        if (bus.d_wr_en && sel && off == 2'd2) m_en = bus.dWdata[0];
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Every cycle, away from the active edge, compare line and bus outputs to the model
    initial begin
        forever begin
            @(negedge clk);
            check_vec("tx", {31'd0, tx}, {31'd0, (m_line.size() > 0) ? m_line[0] : 1'b1});
            check_vec("hit", {31'd0, bus.hit}, {31'd0, bus.dAddr[31:4] == BASE[31:4]});
            check_vec("rdata", bus.dRdata, model_rdata(bus.dAddr));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        bus.d_wr_en = 1'b0;
        bus.dAddr   = 32'h0000_0100;
        bus.dWdata  = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.d_wr_en = 1'b1;
        bus.dAddr   = addr;
        bus.dWdata  = data;
        @(posedge clk);
        #1;
        bus.d_wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
        bus.dAddr = addr;
        #1;
        check_vec(tag, bus.dRdata, exp_v);
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 3000; i++) begin
            if (m_line.size() == 0 && m_fifo.size() == 0) return;
            tick(1);
        end
        check_vec("drain_timeout", 32'd1, 32'd0);
    endtask

    // Samples one 40-cycle frame starting at its first start-bit cycle
    task automatic decode_frame(input string tag, input logic [7:0] exp_b);
        logic [7:0] got;
        logic       st;
        logic       sp;
        got = 8'd0;
        st  = 1'b1;
        sp  = 1'b0;
        for (int c = 0; c < 10 * BAUD; c++) begin
            if (c == 2) st = tx;
            else if (c == 38) sp = tx;
            else if (c >= 6 && c < 38 && (c % 4) == 2) got[(c - 6) / 4] = tx;
            tick(1);
        end
        check_vec({tag, "_start"}, {31'd0, st}, 32'd0);
        check_vec({tag, "_byte"}, {24'd0, got}, {24'd0, exp_b});
        check_vec({tag, "_stop"}, {31'd0, sp}, 32'd1);
    endtask

    initial begin
        int         guard;
        logic [1:0] sel;
        idle_bus();
        tick(2);
        rst = 1'b0;

        // Reset state
        read_check("rst_status", BASE + 32'h4, 32'h0000_0004);
        read_check("rst_ctrl", BASE + 32'h8, 32'h0000_0001);
        bus.dAddr = 32'h0000_0100;
        #1;
        check_vec("rst_hit", {31'd0, bus.hit}, 32'd0);
        check_vec("rst_rdata", bus.dRdata, 32'd0);
        tick(1);

        // Single byte 0x55
        bus_write(BASE, 32'h55);
        check_vec("t1_pre_tx", {31'd0, tx}, 32'd1);
        tick(1);
        check_vec("t1_fall_tx", {31'd0, tx}, 32'd0);
        read_check("t1_busy", BASE + 32'h4, 32'h0000_0005);
        tick(39);
        read_check("t1_last", BASE + 32'h4, 32'h0000_0005);
        tick(1);
        read_check("t1_done", BASE + 32'h4, 32'h0000_0004);
        tick(1);

        // Overflow with enable cleared, then back-to-back drain
        bus_write(BASE + 32'h8, 32'h0);
        for (int i = 1; i <= 9; i++) bus_write(BASE, 32'(i));
        read_check("ovf_status", BASE + 32'h4, 32'h0000_0802);
        bus_write(BASE + 32'h8, 32'h1);
        tick(1);
        for (int f = 0; f < 8; f++) decode_frame("ovf_frame", 8'(f + 1));
        check_vec("ovf_idle_tx", {31'd0, tx}, 32'd1);
        read_check("ovf_end", BASE + 32'h4, 32'h0000_0004);
        tick(1);

        // Push at full on the STOP->START pop edge is dropped
        for (int i = 0; i < 9; i++) bus_write(BASE, $urandom_range(0, 255));
        guard = 0;
        while (m_line.size() != 1 && guard < 100) begin
            tick(1);
            guard++;
        end
        check_vec("pf_wait", 32'(guard < 100), 32'd1);
        bus_write(BASE, 32'hEE);
        read_check("pf_status", BASE + 32'h4, 32'h0000_0701);
        wait_drained();
        tick(1);

        // Enable cleared mid-frame with three bytes queued
        bus_write(BASE, 32'h11);
        bus_write(BASE, 32'h22);
        bus_write(BASE, 32'h33);
        tick(10);
        bus_write(BASE + 32'h8, 32'h0);
        guard = 0;
        while (m_line.size() != 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        check_vec("en_wait", 32'(guard < 100), 32'd1);
        tick(5);
        check_vec("en_hold_tx", {31'd0, tx}, 32'd1);
        read_check("en_hold_st", BASE + 32'h4, 32'h0000_0200);
        tick(10);
        read_check("en_hold_st2", BASE + 32'h4, 32'h0000_0200);
        bus_write(BASE + 32'h8, 32'h1);
        check_vec("en_pre_tx", {31'd0, tx}, 32'd1);
        tick(1);
        decode_frame("en_frame", 8'h22);
        wait_drained();
        tick(1);

        // Asynchronous reset during data bit 3
        bus_write(BASE, 32'h3C);
        bus_write(BASE, 32'h7E);
        tick(17);
        #2;
        rst = 1'b1;
        #1;
        check_vec("mid_rst_tx", {31'd0, tx}, 32'd1);
        read_check("mid_rst_st", BASE + 32'h4, 32'h0000_0004);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        bus_write(BASE, 32'hA5);
        tick(1);
        decode_frame("a5_frame", 8'hA5);
        read_check("a5_end", BASE + 32'h4, 32'h0000_0004);
        tick(1);

        // Randomised bus traffic
        for (int i = 0; i < 400; i++) begin
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) bus.dAddr = 32'h2000_0000 | 32'($urandom_range(0, 255));
            else                           bus.dAddr = BASE | {28'd0, sel, 2'($urandom_range(0, 3))};
            bus.d_wr_en = ($urandom_range(0, 2) != 0);
            bus.dWdata  = $urandom;
            if (sel == 2'd2) bus.dWdata[0] = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        idle_bus();
        bus_write(BASE + 32'h8, 32'h1);
        wait_drained();
        tick(2);
        read_check("final_status", BASE + 32'h4, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
